// File: rtl/fft_r22sdf_bf_pair.sv
// fft_r22sdf_bf_pair: radix-2^2 SDF butterfly pair, BF2I feeding BF2II with trivial -j twiddle
module fft_r22sdf_bf_pair #(
  parameter int DW      = 24,
  parameter int FSR_LEN = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sel1_i,
  input  logic                 sel2_i,
  input  logic signed [DW-1:0] x_re_i,
  input  logic signed [DW-1:0] x_im_i,
  output logic signed [DW-1:0] z_re_o,
  output logic signed [DW-1:0] z_im_o
);
  localparam int L2 = FSR_LEN / 2;
  logic signed [DW-1:0] f1_re_q [FSR_LEN];
  logic signed [DW-1:0] f1_im_q [FSR_LEN];
  logic signed [DW-1:0] f2_re_q [L2];
  logic signed [DW-1:0] f2_im_q [L2];
  logic signed [DW-1:0] f1_re_d, f1_im_d, f2_re_d, f2_im_d;
  logic signed [DW-1:0] t1_re, t1_im, t2_re, t2_im, a_re, a_im, b_re, b_im;
  logic                 rot;
  always_comb begin
    t1_re   = f1_re_q[FSR_LEN-1];
    t1_im   = f1_im_q[FSR_LEN-1];
    t2_re   = f2_re_q[L2-1];
    t2_im   = f2_im_q[L2-1];
    a_re    = sel1_i ? t1_re + x_re_i : t1_re;
    a_im    = sel1_i ? t1_im + x_im_i : t1_im;
    f1_re_d = sel1_i ? t1_re - x_re_i : x_re_i;
    f1_im_d = sel1_i ? t1_im - x_im_i : x_im_i;
    rot     = sel2_i && !sel1_i;
    b_re    = rot ? a_im : a_re;
    b_im    = rot ? -a_re : a_im;
    z_re_o  = sel2_i ? t2_re + b_re : t2_re;
    z_im_o  = sel2_i ? t2_im + b_im : t2_im;
    f2_re_d = sel2_i ? t2_re - b_re : b_re;
    f2_im_d = sel2_i ? t2_im - b_im : b_im;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < FSR_LEN; i++) begin
        f1_re_q[i] <= '0;
        f1_im_q[i] <= '0;
      end
      for (int i = 0; i < L2; i++) begin
        f2_re_q[i] <= '0;
        f2_im_q[i] <= '0;
      end
    end else begin
      f1_re_q[0] <= f1_re_d;
      f1_im_q[0] <= f1_im_d;
      for (int i = 1; i < FSR_LEN; i++) begin
        f1_re_q[i] <= f1_re_q[i-1];
        f1_im_q[i] <= f1_im_q[i-1];
      end
      f2_re_q[0] <= f2_re_d;
      f2_im_q[0] <= f2_im_d;
      for (int i = 1; i < L2; i++) begin
        f2_re_q[i] <= f2_re_q[i-1];
        f2_im_q[i] <= f2_im_q[i-1];
      end
    end
endmodule

// File: tb/tb_fft_r22sdf_bf_pair.sv
// tb_fft_r22sdf_bf_pair: checks two instances (FSR_LEN 2 and 4) against a delay-line model and known DFT results
module tb_fft_r22sdf_bf_pair;
  logic clk = 1'b0, rst_n = 1'b0, sel1 = 1'b0, sel2 = 1'b0;
  logic signed [15:0] x_re = '0, x_im = '0;
  logic signed [15:0] za_re, za_im, zb_re, zb_im;
  int checks = 0, errors = 0;
  logic signed [15:0] m1r [2][4], m1i [2][4], m2r [2][2], m2i [2][2];
  logic signed [15:0] n1r [2], n1i [2], n2r [2], n2i [2];
  logic signed [15:0] er [2], ei [2];
  always #5 clk = ~clk;
  fft_r22sdf_bf_pair #(.DW(16), .FSR_LEN(2)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .sel1_i(sel1), .sel2_i(sel2),
    .x_re_i(x_re), .x_im_i(x_im), .z_re_o(za_re), .z_im_o(za_im));
  fft_r22sdf_bf_pair #(.DW(16), .FSR_LEN(4)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .sel1_i(sel1), .sel2_i(sel2),
    .x_re_i(x_re), .x_im_i(x_im), .z_re_o(zb_re), .z_im_o(zb_im));
  function automatic int len1(input int w); return w ? 4 : 2; endfunction
  function automatic int len2(input int w); return w ? 2 : 1; endfunction
  task automatic model_clear;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin m1r[w][i] = '0; m1i[w][i] = '0; end
      for (int i = 0; i < 2; i++) begin m2r[w][i] = '0; m2i[w][i] = '0; end
    end
  endtask
  task automatic drive(input bit s1, input bit s2, input logic signed [15:0] xr, input logic signed [15:0] xi);
    logic signed [15:0] tr, ti, gr, gi, ar, ai, br, bi;
    sel1 = s1; sel2 = s2; x_re = xr; x_im = xi;
    for (int w = 0; w < 2; w++) begin
      tr = m1r[w][len1(w)-1]; ti = m1i[w][len1(w)-1];
      gr = m2r[w][len2(w)-1]; gi = m2i[w][len2(w)-1];
      ar = s1 ? tr + xr : tr;  ai = s1 ? ti + xi : ti;
      n1r[w] = s1 ? tr - xr : xr; n1i[w] = s1 ? ti - xi : xi;
      if (s2 && !s1) begin br = ai; bi = -ar; end else begin br = ar; bi = ai; end
      er[w] = s2 ? gr + br : gr; ei[w] = s2 ? gi + bi : gi;
      n2r[w] = s2 ? gr - br : br; n2i[w] = s2 ? gi - bi : bi;
    end
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    if (rst_n)
      for (int w = 0; w < 2; w++) begin
        for (int i = len1(w)-1; i > 0; i--) begin m1r[w][i] = m1r[w][i-1]; m1i[w][i] = m1i[w][i-1]; end
        m1r[w][0] = n1r[w]; m1i[w][0] = n1i[w];
        for (int i = len2(w)-1; i > 0; i--) begin m2r[w][i] = m2r[w][i-1]; m2i[w][i] = m2i[w][i-1]; end
        m2r[w][0] = n2r[w]; m2i[w][0] = n2i[w];
      end
    #1;
  endtask
  task automatic pulse_reset;
    rst_n = 1'b0; model_clear(); #2; rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; model_clear();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      checks++;
      if ({za_re, za_im, zb_re, zb_im} !== 64'd0) begin
        errors++; $display("FAIL reset_zero: a=(%0d,%0d) b=(%0d,%0d) want 0", za_re, za_im, zb_re, zb_im);
      end
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom));
      checks++;
      if (za_re !== x_re || za_im !== x_im || zb_re !== x_re || zb_im !== x_im) begin
        errors++; $display("FAIL reset_pass: a=(%0d,%0d) b=(%0d,%0d) want (%0d,%0d)", za_re, za_im, zb_re, zb_im, x_re, x_im);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask
  task automatic run_dft(input bit imag, input string tag);
    int v [7] = '{1, 2, 3, 4, 0, 0, 0};
    bit s2t [7] = '{0, 0, 0, 1, 0, 1, 0};
    int rr [4] = '{10, -2, -2, -2}, ri [4] = '{0, 0, 2, -2};
    int ir [4] = '{0, 0, -2, 2},   ii [4] = '{10, -2, -2, -2};
    logic signed [15:0] wr, wi;
    for (int c = 0; c < 7; c++) begin
      drive(c[1], s2t[c], imag ? 16'sd0 : 16'(v[c]), imag ? 16'(v[c]) : 16'sd0);
      if (c >= 3) begin
        wr = imag ? 16'(ir[c-3]) : 16'(rr[c-3]);
        wi = imag ? 16'(ii[c-3]) : 16'(ri[c-3]);
        checks++;
        if (za_re !== wr || za_im !== wi) begin
          errors++; $display("FAIL %s c%0d: got (%0d,%0d) want (%0d,%0d)", tag, c, za_re, za_im, wr, wi);
        end
      end
      checks++;
      if (zb_re !== er[1] || zb_im !== ei[1]) begin
        errors++; $display("FAIL %s_b c%0d: got (%0d,%0d) want (%0d,%0d)", tag, c, zb_re, zb_im, er[1], ei[1]);
      end
      tick();
    end
  endtask
  task automatic test_dft;
    pulse_reset(); run_dft(1'b0, "dft_re");
    pulse_reset(); run_dft(1'b1, "dft_im");
  endtask
  task automatic test_fill;
    logic signed [15:0] hr [$], hi [$];
    pulse_reset();
    for (int n = 0; n < 14; n++) begin
      drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      hr.push_back(x_re); hi.push_back(x_im);
      if (n >= 3) begin
        checks++;
        if (za_re !== hr[n-3] || za_im !== hi[n-3]) begin
          errors++; $display("FAIL fill_a n%0d: got (%0d,%0d) want (%0d,%0d)", n, za_re, za_im, hr[n-3], hi[n-3]);
        end
      end
      if (n >= 6) begin
        checks++;
        if (zb_re !== hr[n-6] || zb_im !== hi[n-6]) begin
          errors++; $display("FAIL fill_b n%0d: got (%0d,%0d) want (%0d,%0d)", n, zb_re, zb_im, hr[n-6], hi[n-6]);
        end
      end
      tick();
    end
  endtask
  task automatic test_wrap;
    pulse_reset();
    drive(1'b0, 1'b0, 16'sd32767, 16'sd0); tick();
    drive(1'b0, 1'b0, 16'sd0, 16'sd0); tick();
    drive(1'b1, 1'b0, 16'sd1, 16'sd0); tick();
    drive(1'b1, 1'b0, 16'sd0, 16'sd0);
    checks++;
    if (za_re !== -16'sd32768) begin
      errors++; $display("FAIL wrap_sum: got %0d want -32768", za_re);
    end
    tick();
    drive(1'b0, 1'b0, 16'sd0, 16'sd0); tick();
    drive(1'b0, 1'b0, 16'sd0, 16'sd0);
    checks++;
    if (za_re !== 16'sd32766) begin
      errors++; $display("FAIL wrap_diff: got %0d want 32766", za_re);
    end
    tick();
  endtask
  task automatic test_twiddle;
    logic signed [15:0] wr [4] = '{16'sd0, 16'sd5, 16'sd0, 16'sd3};
    logic signed [15:0] wi [4] = '{16'sd0, -16'sd3, 16'sd0, 16'sd5};
    for (int k = 0; k < 4; k++) begin
      pulse_reset();
      if (!k[1]) begin
        drive(1'b0, 1'b0, 16'sd3, 16'sd5); tick();
        drive(1'b0, 1'b0, 16'sd0, 16'sd0); tick();
        drive(1'b0, k[0], 16'sd0, 16'sd0);
      end else drive(1'b1, k[0], 16'sd3, 16'sd5);
      checks++;
      if (za_re !== wr[k] || za_im !== wi[k]) begin
        errors++; $display("FAIL twiddle s1=%0d s2=%0d: got (%0d,%0d) want (%0d,%0d)", k[1], k[0], za_re, za_im, wr[k], wi[k]);
      end
      tick();
    end
  endtask
  task automatic test_random(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      checks++;
      if (za_re !== er[0] || za_im !== ei[0] || zb_re !== er[1] || zb_im !== ei[1]) begin
        errors++; $display("FAIL %s c%0d: a=(%0d,%0d) want (%0d,%0d) b=(%0d,%0d) want (%0d,%0d)", tag, c,
          za_re, za_im, er[0], ei[0], zb_re, zb_im, er[1], ei[1]);
      end
      tick();
    end
  endtask
  task automatic test_async_reset;
    pulse_reset();
    test_random(9, "pre_reset");
    rst_n = 1'b0; model_clear();
    drive(1'b1, 1'b1, 16'sd0, 16'sd0);
    checks++;
    if ({za_re, za_im, zb_re, zb_im} !== 64'd0) begin
      errors++; $display("FAIL async_clear: a=(%0d,%0d) b=(%0d,%0d) want 0", za_re, za_im, zb_re, zb_im);
    end
    #1; rst_n = 1'b1;
    run_dft(1'b0, "dft_after_reset");
  endtask
  initial begin
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_dft();
    test_fill();
    test_wrap();
    test_twiddle();
    test_async_reset();
    pulse_reset();
    test_random(300, "random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
